// File: rtl/cache_miss_handler_pkg.sv
// cache_pkg: shared definitions for the cache miss handler.
//   cmh_state_t  - controller state encoding
//   SET_BITS, TAG_BITS, WAYS, DATA_WIDTH - cache geometry (16 sets x 4 ways, word lines)
//   ADDR_WIDTH   - byte address width implied by tag + index + byte offset
//   word_align() - clears the byte offset of an address
package cache_pkg;

    localparam int SET_BITS   = 4;
    localparam int TAG_BITS   = 26;
    localparam int WAYS       = 4;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = TAG_BITS + SET_BITS + 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_FILL = 3'd3,
        ST_WR_REQ  = 3'd4
    } cmh_state_t;

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        return addr & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/cache_miss_handler_sat_counter.sv
// sat_counter: event counter that stops at all-ones instead of wrapping.
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset, clears the count
//   inc_i   - count one event this cycle
//   count_o - current count
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cache_miss_handler.sv
// cache_miss_handler: glue between the CPU load/store port, a word cache and
// main memory. Load hits complete in the IDLE cycle; load misses fetch the
// word from memory, fill the cache and return it; stores are write-through.
//
// Ports:
//   clk_i, rst_i                 - clock, asynchronous active-high reset
//   cpu_req_valid_i/we/addr/wdata - CPU access, held while stall_o=1
//   cpu_rdata_o, stall_o         - load data, CPU hold request
//   cache_hit_i, cache_rdata_i   - cache lookup result for cache_addr_o
//   cache_addr_o/we_o/wdata_o    - cache lookup address and write port
//   mem_req_*                    - memory request channel
//   mem_resp_valid_i/rdata_i     - memory read response
//   hit_count_o, miss_count_o    - saturating load hit/miss counters
//   err_o                        - sticky read-timeout flag
//
// Handshake: a memory request transfers in a cycle where mem_req_valid_o and
// mem_req_ready_i are both 1; until then valid stays 1 and address/data stay
// stable. A read response is a single cycle with mem_resp_valid_i=1 and is
// only consumed in RD_WAIT.
module cache_miss_handler
    import cache_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_valid_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  stall_o,
    input  logic                  cache_hit_i,
    input  logic [DATA_WIDTH-1:0] cache_rdata_i,
    output logic [ADDR_WIDTH-1:0] cache_addr_o,
    output logic                  cache_we_o,
    output logic [DATA_WIDTH-1:0] cache_wdata_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_req_we_o,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic [DATA_WIDTH-1:0] mem_req_wdata_o,
    input  logic                  mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata_i,
    output logic [CNT_WIDTH-1:0]  hit_count_o,
    output logic [CNT_WIDTH-1:0]  miss_count_o,
    output logic                  err_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    cmh_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    // Cleared when the fill came from a timeout so the cache is not polluted.
    logic                  fill_ok_q, fill_ok_d;
    logic                  err_q, err_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  hit_inc, miss_inc;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        fill_d    = fill_q;
        fill_ok_d = fill_ok_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;

        cpu_rdata_o     = '0;
        stall_o         = 1'b0;
        cache_addr_o    = addr_q;
        cache_we_o      = 1'b0;
        cache_wdata_o   = '0;
        mem_req_valid_o = 1'b0;
        mem_req_we_o    = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_wdata_o = '0;

        case (state_q)
            ST_IDLE: begin
                cache_addr_o = cpu_addr_i;
                cpu_rdata_o  = cache_rdata_i;
                if (cpu_req_valid_i) begin
                    if (cpu_we_i) begin
                        stall_o = 1'b1;
                        addr_d  = cpu_addr_i;
                        wdata_d = cpu_wdata_i;
                        state_d = ST_WR_REQ;
                    end else if (cache_hit_i) begin
                        hit_inc = 1'b1;
                    end else begin
                        stall_o  = 1'b1;
                        addr_d   = cpu_addr_i;
                        miss_inc = 1'b1;
                        state_d  = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = word_align(addr_q);
                stall_o         = 1'b1;
                if (mem_req_ready_i) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                stall_o = 1'b1;
                if (mem_resp_valid_i) begin
                    fill_d    = mem_resp_rdata_i;
                    fill_ok_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = ST_RD_FILL;
                end else if (tmo_q == TMO_LAST) begin
                    // This is the last allowed wait cycle: abort with zero data.
                    err_d     = 1'b1;
                    fill_d    = '0;
                    fill_ok_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = ST_RD_FILL;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RD_FILL: begin
                cache_we_o    = fill_ok_q;
                cache_wdata_o = fill_q;
                cpu_rdata_o   = fill_q;
                state_d       = ST_IDLE;
            end
            ST_WR_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_we_o    = 1'b1;
                mem_req_addr_o  = word_align(addr_q);
                mem_req_wdata_o = wdata_q;
                stall_o         = ~mem_req_ready_i;
                if (mem_req_ready_i) begin
                    cache_we_o    = 1'b1;
                    cache_wdata_o = wdata_q;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            fill_q    <= '0;
            fill_ok_q <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            fill_q    <= fill_d;
            fill_ok_q <= fill_ok_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign err_o = err_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (hit_inc),
        .count_o (hit_count_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (miss_inc),
        .count_o (miss_count_o)
    );

endmodule

// File: tb/tb_cache_miss_handler.sv
module tb_cache_miss_handler;

  localparam int TMO = 8;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_req_valid_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [31:0] cpu_rdata_o;
  logic        stall_o;
  logic        cache_hit_i;
  logic [31:0] cache_rdata_i;
  logic [31:0] cache_addr_o;
  logic        cache_we_o;
  logic [31:0] cache_wdata_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_req_we_o;
  logic [31:0] mem_req_addr_o;
  logic [31:0] mem_req_wdata_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_rdata_i;
  logic [CW-1:0] hit_count_o;
  logic [CW-1:0] miss_count_o;
  logic        err_o;

  cache_miss_handler #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_valid_i(cpu_req_valid_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o), .stall_o(stall_o),
    .cache_hit_i(cache_hit_i), .cache_rdata_i(cache_rdata_i),
    .cache_addr_o(cache_addr_o), .cache_we_o(cache_we_o), .cache_wdata_o(cache_wdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_rdata_i(mem_resp_rdata_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o), .err_o(err_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- environment: cache array and memory device ----------------
  logic [31:0] cache_mem [0:4095];
  bit          cache_vld [0:4095];
  logic [31:0] dev_mem   [0:4095];

  assign cache_hit_i   = cache_vld[cache_addr_o[13:2]];
  assign cache_rdata_i = cache_mem[cache_addr_o[13:2]];

  // ---------------- reference model (coherent memory view) ----------------
  logic [31:0] ref_mem [0:4095];
  bit          touched [0:4095];
  int          ref_hits;
  int          ref_miss;

  typedef struct {
    logic        we;
    logic [31:0] rdata;
    logic        cwe;
    logic [31:0] cwdata;
    logic [31:0] caddr;
  } cpu_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  int checks;
  int failures;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- memory responder ----------------
  int          ready_mode;   // 0 random, 1 always ready, 2 ready after hold_n cycles
  int          hold_n;
  int          wait_cnt;
  bit          no_resp;
  int          fixed_delay;  // 0 = random 1..4
  int          resp_cnt;
  logic [31:0] resp_data;
  bit          stale_req;

  always @(posedge clk_i) begin
    #1;
    mem_resp_valid_i = 1'b0;
    mem_resp_rdata_i = '0;
    if (stale_req) begin
      mem_resp_valid_i = 1'b1;
      mem_resp_rdata_i = 32'hBADB_AD00;
      stale_req = 1'b0;
    end
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        mem_resp_valid_i = 1'b1;
        mem_resp_rdata_i = resp_data;
      end
    end
    if (mem_req_valid_o) begin
      case (ready_mode)
        0:       mem_req_ready_i = 1'($urandom_range(0, 1));
        1:       mem_req_ready_i = 1'b1;
        default: mem_req_ready_i = (wait_cnt >= hold_n);
      endcase
      wait_cnt++;
    end else begin
      mem_req_ready_i = 1'b0;
      wait_cnt = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (mem_req_valid_o) begin
        if (mem_q.size() == 0) begin
          fail_now("mem_unexpected_req");
        end else begin
          check32("mem_req_we", {31'b0, mem_req_we_o}, {31'b0, mem_q[0].we});
          check32("mem_req_addr", mem_req_addr_o, mem_q[0].addr);
          check32("mem_req_wdata", mem_req_wdata_o, mem_q[0].wdata);
          if (mem_req_ready_i) begin
            void'(mem_q.pop_front());
            if (mem_req_we_o) begin
              dev_mem[mem_req_addr_o[13:2]] = mem_req_wdata_o;
            end else if (!no_resp) begin
              resp_cnt  = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 4);
              resp_data = dev_mem[mem_req_addr_o[13:2]];
            end
          end
        end
      end

      if (cpu_req_valid_i && !stall_o) begin
        if (cpu_q.size() == 0) begin
          fail_now("cpu_unexpected_completion");
        end else begin
          cpu_exp_t e;
          e = cpu_q.pop_front();
          check32(e.we ? "st_cpu_rdata" : "ld_cpu_rdata", cpu_rdata_o, e.rdata);
          check32("cache_we", {31'b0, cache_we_o}, {31'b0, e.cwe});
          check32("cache_wdata", cache_wdata_o, e.cwdata);
          check32("cache_addr", cache_addr_o, e.caddr);
        end
      end else if (cache_we_o) begin
        fail_now("cache_we_spurious");
      end

      if (cache_we_o) begin
        cache_mem[cache_addr_o[13:2]] = cache_wdata_o;
        cache_vld[cache_addr_o[13:2]] = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input bit exp_tmo, output int stalls, output int mv, output int cwe);
    int       w;
    bit       hit;
    bit       done;
    cpu_exp_t e;
    mem_exp_t m;
    w   = int'(addr[13:2]);
    hit = !we && touched[w];
    e.we     = we;
    e.rdata  = (we || exp_tmo) ? 32'h0 : ref_mem[w];
    e.cwe    = we ? 1'b1 : (hit ? 1'b0 : !exp_tmo);
    e.cwdata = we ? wd : (hit ? 32'h0 : e.rdata);
    e.caddr  = addr;
    cpu_q.push_back(e);
    if (!hit) begin
      m.we    = we;
      m.addr  = addr & 32'hFFFF_FFFC;
      m.wdata = we ? wd : 32'h0;
      mem_q.push_back(m);
    end
    if (we) begin
      ref_mem[w] = wd;
      touched[w] = 1'b1;
    end else if (hit) begin
      ref_hits++;
    end else begin
      ref_miss++;
      if (!exp_tmo) touched[w] = 1'b1;
    end

    cpu_req_valid_i = 1'b1;
    cpu_we_i        = we;
    cpu_addr_i      = addr;
    cpu_wdata_i     = wd;
    stalls = 0;
    mv     = 0;
    cwe    = 0;
    done   = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk_i);
      if (mem_req_valid_o) mv++;
      if (cache_we_o) cwe++;
      if (!stall_o) done = 1'b1;
      else stalls++;
    end
    if (!done) fail_now("access_cycle_budget");
    if (hit) check32("hit_no_stall", 32'(stalls), 32'd0);
    @(posedge clk_i);
    #1;
    cpu_req_valid_i = 1'b0;
    cpu_we_i        = 1'b0;
    cpu_addr_i      = '0;
    cpu_wdata_i     = '0;
    check32("hit_count", {28'b0, hit_count_o}, 32'((ref_hits > SAT) ? SAT : ref_hits));
    check32("miss_count", {28'b0, miss_count_o}, 32'((ref_miss > SAT) ? SAT : ref_miss));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int st, mv, cw;
    for (int i = 0; i < 4096; i++) begin
      dev_mem[i]   = 32'h5A00_0000 + 32'(i) * 32'd7919;
      ref_mem[i]   = 32'h5A00_0000 + 32'(i) * 32'd7919;
      cache_mem[i] = '0;
      cache_vld[i] = 1'b0;
      touched[i]   = 1'b0;
    end
    checks = 0; failures = 0; ref_hits = 0; ref_miss = 0;
    ready_mode = 1; hold_n = 0; wait_cnt = 0; no_resp = 1'b0; fixed_delay = 0;
    resp_cnt = 0; resp_data = '0; stale_req = 1'b0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_rdata_i = '0;
    cpu_req_valid_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;

    // reset state
    rst_i = 1'b1;
    #12;
    check32("rst_stall", {31'b0, stall_o}, 32'd0);
    check32("rst_mem_valid", {31'b0, mem_req_valid_o}, 32'd0);
    check32("rst_cache_we", {31'b0, cache_we_o}, 32'd0);
    check32("rst_err", {31'b0, err_o}, 32'd0);
    check32("rst_hit_count", {28'b0, hit_count_o}, 32'd0);
    check32("rst_miss_count", {28'b0, miss_count_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // load hit at 0x40
    dev_mem[16] = 32'hDEAD_BEEF; ref_mem[16] = 32'hDEAD_BEEF;
    cache_mem[16] = 32'hDEAD_BEEF; cache_vld[16] = 1'b1; touched[16] = 1'b1;
    do_access(1'b0, 32'h40, 32'h0, 1'b0, st, mv, cw);
    check32("t1_stalls", 32'(st), 32'd0);

    // load miss at 0x1003, response 3 cycles after accept
    dev_mem[12'h400] = 32'hCAFE_F00D; ref_mem[12'h400] = 32'hCAFE_F00D;
    ready_mode = 1; fixed_delay = 3;
    do_access(1'b0, 32'h1003, 32'h0, 1'b0, st, mv, cw);
    check32("t2_stalls", 32'(st), 32'd5);
    check32("t2_fill_pulses", 32'(cw), 32'd1);

    // store with ready low for 4 cycles
    ready_mode = 2; hold_n = 4;
    do_access(1'b1, 32'h80, 32'h1234_5678, 1'b0, st, mv, cw);
    check32("t3_stalls", 32'(st), 32'd5);
    check32("t3_mem_valid_cycles", 32'(mv), 32'd5);
    check32("t3_cache_we_pulses", 32'(cw), 32'd1);

    // read timeout
    ready_mode = 1; no_resp = 1'b1;
    do_access(1'b0, 32'h200, 32'h0, 1'b1, st, mv, cw);
    check32("t4_stalls", 32'(st), 32'd10);
    check32("t4_cache_we_pulses", 32'(cw), 32'd0);
    check32("t4_err_set", {31'b0, err_o}, 32'd1);
    no_resp = 1'b0;
    do_access(1'b0, 32'h40, 32'h0, 1'b0, st, mv, cw);
    do_access(1'b1, 32'h84, 32'h0BAD_F00D, 1'b0, st, mv, cw);
    check32("t4_err_sticky", {31'b0, err_o}, 32'd1);

    // reset while waiting for a read response, then a stale response
    no_resp = 1'b1;
    begin
      mem_exp_t m;
      m.we = 1'b0; m.addr = 32'h300; m.wdata = 32'h0;
      mem_q.push_back(m);
    end
    cpu_req_valid_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h300;
    repeat (3) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    cpu_req_valid_i = 1'b0; cpu_addr_i = '0;
    #1;
    check32("t5_rst_stall", {31'b0, stall_o}, 32'd0);
    check32("t5_rst_mem_valid", {31'b0, mem_req_valid_o}, 32'd0);
    check32("t5_rst_err", {31'b0, err_o}, 32'd0);
    check32("t5_rst_miss_count", {28'b0, miss_count_o}, 32'd0);
    ref_hits = 0; ref_miss = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    stale_req = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      check32("t5_stale_stall", {31'b0, stall_o}, 32'd0);
      check32("t5_stale_mem_valid", {31'b0, mem_req_valid_o}, 32'd0);
      check32("t5_stale_cache_we", {31'b0, cache_we_o}, 32'd0);
      check32("t5_stale_counts", {24'b0, hit_count_o, miss_count_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    no_resp = 1'b0;

    // counter saturation: 20 hits
    for (int i = 0; i < 20; i++) begin
      do_access(1'b0, 32'h40 | 32'($urandom_range(0, 3)), 32'h0, 1'b0, st, mv, cw);
    end
    check32("t6_hit_saturated", {28'b0, hit_count_o}, 32'h0000_000F);

    // randomized traffic
    ready_mode = 0; fixed_delay = 0;
    for (int n = 0; n < 150; n++) begin
      logic        we;
      logic [31:0] addr;
      we   = ($urandom_range(0, 2) == 0);
      addr = (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
      do_access(we, addr, $urandom, 1'b0, st, mv, cw);
    end

    repeat (3) @(negedge clk_i);
    check32("end_cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    check32("end_mem_q_empty", 32'(mem_q.size()), 32'd0);
    check32("end_err_clear", {31'b0, err_o}, 32'd0);
    check32("end_hit_count", {28'b0, hit_count_o}, 32'((ref_hits > SAT) ? SAT : ref_hits));
    check32("end_miss_count", {28'b0, miss_count_o}, 32'((ref_miss > SAT) ? SAT : ref_miss));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
